// File: rtl/otfs_symbol_error_checker_if.sv
// Bundle of the checker's control, symbol-stream and report signals.
// The master side drives the symbol streams; the slave side is the checker.
interface otfs_symbol_error_checker_if #(
  parameter int SYM_W   = 5,
  parameter int FIFO_AW = 8,
  parameter int TOT_W   = 32
);
  logic               Start;
  logic [2:0]         ModulationOrder;
  logic               TxSymValid;
  logic [SYM_W-1:0]   TxSym;
  logic               RxSymValid;
  logic [SYM_W-1:0]   RxSym;
  logic               ReportValid;
  logic [7:0]         FrameSymErrors;
  logic [10:0]        FrameBitErrors;
  logic [TOT_W-1:0]   TotalBitErrors;
  logic [15:0]        FramesChecked;
  logic [FIFO_AW:0]   FifoLevel;
  logic               Overflow;
  logic               Underflow;

  modport master (
    output Start, ModulationOrder, TxSymValid, TxSym, RxSymValid, RxSym,
    input  ReportValid, FrameSymErrors, FrameBitErrors, TotalBitErrors,
           FramesChecked, FifoLevel, Overflow, Underflow
  );

  modport slave (
    input  Start, ModulationOrder, TxSymValid, TxSym, RxSymValid, RxSym,
    output ReportValid, FrameSymErrors, FrameBitErrors, TotalBitErrors,
           FramesChecked, FifoLevel, Overflow, Underflow
  );
endinterface

// File: rtl/otfs_symbol_error_checker.sv
// Symbol/bit error checker: FIFO of transmitted symbols compared against
// demodulated symbols, with per-frame and running error reports.
module otfs_symbol_error_checker #(
  parameter int SYM_W     = 5,
  parameter int FRAME_LEN = 64,
  parameter int FIFO_AW   = 8,
  parameter int TOT_W     = 32
) (
  input  logic Clk,
  input  logic SRst,
  otfs_symbol_error_checker_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int BC_W  = $clog2(SYM_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [SYM_W-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic [SYM_W-1:0]   mask;
  logic [IDX_W-1:0]   rx_idx;

  logic               s1_valid, s1_sym_err, s1_last;
  logic [BC_W-1:0]    s1_bit_err;
  logic [7:0]         acc_sym;
  logic [10:0]        acc_bit;

  logic               report_valid, overflow, underflow;
  logic [7:0]         frame_sym;
  logic [10:0]        frame_bit;
  logic [TOT_W-1:0]   total_bit;
  logic [15:0]        frames_checked;

  logic               clr, full, empty, push_ok, pop_ok;
  logic [SYM_W-1:0]   head, diff, mask_sel;
  logic [BC_W-1:0]    bit_cnt;
  logic [TOT_W:0]     total_sum;

  assign clr   = SRst | bus.Start;
  assign full  = level[FIFO_AW];
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign pop_ok  = bus.RxSymValid & ~empty;
  assign push_ok = bus.TxSymValid & (~full | pop_ok);

  always_comb begin
    mask_sel = '1;
    case (bus.ModulationOrder)
      3'b001:  mask_sel = {SYM_W{1'b1}} >> 1;
      3'b010:  mask_sel = {SYM_W{1'b1}} >> (SYM_W - 2);
      default: mask_sel = '1;
    endcase
  end

  // An empty pop has no reference symbol, so every valid bit is an error.
  always_comb begin
    diff    = empty ? mask : ((head ^ bus.RxSym) & mask);
    bit_cnt = '0;
    for (int i = 0; i < SYM_W; i++) begin
      bit_cnt = bit_cnt + BC_W'(diff[i]);
    end
  end

  assign total_sum = {1'b0, total_bit} + (TOT_W + 1)'(s1_bit_err);

  always_ff @(posedge Clk) begin
    if (push_ok && !clr) mem[wr_ptr] <= bus.TxSym;
  end

  always_ff @(posedge Clk) begin
    if (clr) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      mask           <= SRst ? '1 : mask_sel;
      rx_idx         <= '0;
      s1_valid       <= 1'b0;
      s1_sym_err     <= 1'b0;
      s1_bit_err     <= '0;
      s1_last        <= 1'b0;
      acc_sym        <= '0;
      acc_bit        <= '0;
      report_valid   <= 1'b0;
      frame_sym      <= '0;
      frame_bit      <= '0;
      total_bit      <= '0;
      frames_checked <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (FIFO_AW + 1)'(push_ok) - (FIFO_AW + 1)'(pop_ok);
      if (bus.TxSymValid && full && !pop_ok) overflow  <= 1'b1;
      if (bus.RxSymValid && empty)           underflow <= 1'b1;

      s1_valid <= bus.RxSymValid;
      if (bus.RxSymValid) begin
        s1_sym_err <= |diff;
        s1_bit_err <= bit_cnt;
        s1_last    <= (rx_idx == LAST_IDX);
        rx_idx     <= (rx_idx == LAST_IDX) ? '0 : rx_idx + 1'b1;
      end

      report_valid <= 1'b0;
      if (s1_valid) begin
        total_bit <= total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
        if (s1_last) begin
          report_valid   <= 1'b1;
          frame_sym      <= acc_sym + 8'(s1_sym_err);
          frame_bit      <= acc_bit + 11'(s1_bit_err);
          acc_sym        <= '0;
          acc_bit        <= '0;
          frames_checked <= frames_checked + 1'b1;
        end else begin
          acc_sym <= acc_sym + 8'(s1_sym_err);
          acc_bit <= acc_bit + 11'(s1_bit_err);
        end
      end
    end
  end

  assign bus.ReportValid    = report_valid;
  assign bus.FrameSymErrors = frame_sym;
  assign bus.FrameBitErrors = frame_bit;
  assign bus.TotalBitErrors = total_bit;
  assign bus.FramesChecked  = frames_checked;
  assign bus.FifoLevel      = level;
  assign bus.Overflow       = overflow;
  assign bus.Underflow      = underflow;
endmodule

// File: tb/tb_otfs_symbol_error_checker.sv
// Bench for otfs_symbol_error_checker: table of single-frame vectors plus
// hand sequences; expected frame reports are queued and matched on output.
module tb_otfs_symbol_error_checker;
  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  otfs_symbol_error_checker_if #(.SYM_W(5), .FIFO_AW(8), .TOT_W(32)) bus ();

  otfs_symbol_error_checker #(.SYM_W(5), .FRAME_LEN(64), .FIFO_AW(8), .TOT_W(32)) dut (
    .Clk (clk),
    .SRst(srst),
    .bus (bus)
  );

  typedef struct {
    bit       do_start;
    logic [2:0] mod;
    bit       tx_count;
    logic [4:0] xor_all;
    int       e0_idx;
    logic [4:0] e0_xor;
    int       e1_idx;
    logic [4:0] e1_xor;
    int       exp_sym;
    int       exp_bit;
  } vec_t;

  typedef struct {
    int     sym;
    int     bits;
    longint tot;
    int     frames;
  } rep_t;

  rep_t   sb[$];
  int     rep_cyc[$];
  vec_t   vecs[6];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     last_pop_cyc;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    rep_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (bus.ReportValid) begin
      rep_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_report: got ReportValid=1 at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("frame_sym_errors", bus.FrameSymErrors, e.sym);
        check("frame_bit_errors", bus.FrameBitErrors, e.bits);
        check("total_bit_errors", bus.TotalBitErrors, e.tot);
        check("frames_checked", bus.FramesChecked, e.frames);
      end
    end
  endtask

  task automatic do_start(input logic [2:0] mod);
    bus.Start = 1'b1;
    bus.ModulationOrder = mod;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic push(input logic [4:0] s);
    bus.TxSymValid = 1'b1;
    bus.TxSym = s;
    tick();
    bus.TxSymValid = 1'b0;
  endtask

  task automatic pop(input logic [4:0] s);
    bus.RxSymValid = 1'b1;
    bus.RxSym = s;
    tick();
    bus.RxSymValid = 1'b0;
    last_pop_cyc = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 10) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL report_timeout: got %0d reports missing expected 0", sb.size());
      sb.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    logic [4:0] tx, rx;
    int nrep;

    vecs[0] = '{1'b0, 3'b010, 1'b1, 5'b00000,  0, 5'b11100, -1, 5'b00000,  1,   3};
    vecs[1] = '{1'b1, 3'b000, 1'b1, 5'b00000, -1, 5'b00000, -1, 5'b00000,  0,   0};
    vecs[2] = '{1'b1, 3'b000, 1'b1, 5'b00000,  3, 5'b00001, 10, 5'b10110,  2,   4};
    vecs[3] = '{1'b1, 3'b010, 1'b0, 5'b11100, -1, 5'b00000, -1, 5'b00000,  0,   0};
    vecs[4] = '{1'b1, 3'b001, 1'b0, 5'b11111, -1, 5'b00000, -1, 5'b00000, 64, 256};
    vecs[5] = '{1'b1, 3'b111, 1'b0, 5'b00000,  0, 5'b10000, 63, 5'b11111,  2,   6};

    srst = 1'b1;
    bus.Start = 1'b0;
    bus.ModulationOrder = 3'b010;
    bus.TxSymValid = 1'b0;
    bus.TxSym = '0;
    bus.RxSymValid = 1'b0;
    bus.RxSym = '0;
    repeat (3) tick();
    srst = 1'b0;
    tick();
    check("rst_report_valid", bus.ReportValid, 0);
    check("rst_frame_sym", bus.FrameSymErrors, 0);
    check("rst_frame_bit", bus.FrameBitErrors, 0);
    check("rst_total_bit", bus.TotalBitErrors, 0);
    check("rst_frames", bus.FramesChecked, 0);
    check("rst_level", bus.FifoLevel, 0);
    check("rst_overflow", bus.Overflow, 0);
    check("rst_underflow", bus.Underflow, 0);

    // Single-frame vectors; row 0 runs on the reset mask (all 5 bits).
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_start) do_start(vecs[v].mod);
      for (int i = 0; i < 64; i++) push(vecs[v].tx_count ? 5'(i % 32) : 5'b00000);
      check("level_after_push", bus.FifoLevel, 64);
      sb.push_back('{vecs[v].exp_sym, vecs[v].exp_bit, longint'(vecs[v].exp_bit), 1});
      nrep = rep_cyc.size();
      for (int i = 0; i < 64; i++) begin
        tx = vecs[v].tx_count ? 5'(i % 32) : 5'b00000;
        rx = tx ^ vecs[v].xor_all;
        if (i == vecs[v].e0_idx) rx = rx ^ vecs[v].e0_xor;
        if (i == vecs[v].e1_idx) rx = rx ^ vecs[v].e1_xor;
        pop(rx);
      end
      drain();
      check("reports_in_frame", rep_cyc.size() - nrep, 1);
      if (rep_cyc.size() > nrep) check("report_latency", rep_cyc[nrep] - last_pop_cyc, 1);
      check("level_after_frame", bus.FifoLevel, 0);
      check("no_underflow", bus.Underflow, 0);
    end

    // Back-to-back frames: accumulators restart, totals carry, 64-cycle spacing.
    do_start(3'b000);
    for (int i = 0; i < 128; i++) push(5'b00000);
    sb.push_back('{1, 3, 3, 1});
    sb.push_back('{0, 0, 3, 2});
    nrep = rep_cyc.size();
    for (int i = 0; i < 128; i++) pop((i == 5) ? 5'b00111 : 5'b00000);
    drain();
    check("b2b_reports", rep_cyc.size() - nrep, 2);
    if (rep_cyc.size() >= nrep + 2) check("b2b_spacing", rep_cyc[nrep+1] - rep_cyc[nrep], 64);

    // Underflow: every Rx symbol on an empty FIFO is a full-mask error.
    do_start(3'b000);
    check("uf_before", bus.Underflow, 0);
    sb.push_back('{64, 320, 320, 1});
    pop(5'b00000);
    check("uf_rise", bus.Underflow, 1);
    for (int i = 1; i < 64; i++) pop(5'b00000);
    drain();
    check("uf_sticky", bus.Underflow, 1);
    check("uf_level", bus.FifoLevel, 0);

    // Overflow at 257th push, then full push+pop keeps the level.
    do_start(3'b000);
    for (int i = 0; i < 257; i++) begin
      push(5'(i));
      if (i == 255) begin
        check("ovf_level_full", bus.FifoLevel, 256);
        check("ovf_not_yet", bus.Overflow, 0);
      end
    end
    check("ovf_rise", bus.Overflow, 1);
    check("ovf_level_hold", bus.FifoLevel, 256);
    bus.TxSymValid = 1'b1;
    bus.TxSym = 5'd7;
    bus.RxSymValid = 1'b1;
    bus.RxSym = 5'd0;
    tick();
    bus.TxSymValid = 1'b0;
    bus.RxSymValid = 1'b0;
    check("ovf_pushpop_level", bus.FifoLevel, 256);
    check("ovf_pushpop_uf", bus.Underflow, 0);
    do_start(3'b000);
    check("start_clears_ovf", bus.Overflow, 0);
    check("start_clears_level", bus.FifoLevel, 0);

    // Start mid-frame with push/pop on the Start cycle: all discarded.
    for (int i = 0; i < 30; i++) push(5'b00000);
    for (int i = 0; i < 30; i++) pop(5'b11111);
    bus.Start = 1'b1;
    bus.ModulationOrder = 3'b000;
    bus.TxSymValid = 1'b1;
    bus.TxSym = 5'b11111;
    bus.RxSymValid = 1'b1;
    bus.RxSym = 5'b00000;
    tick();
    bus.Start = 1'b0;
    bus.TxSymValid = 1'b0;
    bus.RxSymValid = 1'b0;
    check("mid_start_level", bus.FifoLevel, 0);
    check("mid_start_total", bus.TotalBitErrors, 0);
    for (int i = 0; i < 64; i++) push(5'(i % 32));
    sb.push_back('{0, 0, 0, 1});
    nrep = rep_cyc.size();
    for (int i = 0; i < 64; i++) pop(5'(i % 32));
    drain();
    check("mid_reports", rep_cyc.size() - nrep, 1);
    check("mid_frames", bus.FramesChecked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
